// File: rtl/sram_sp_masked_ctrl_pkg.sv
// Shared types and helpers for the lane-masked single-port SRAM controller.
// Parity support is built only when SRAM_PARITY_EN is defined.
package sram_ctrl_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // Upper bound on lane width accepted by lane_parity.
  localparam int LANE_W_MAX = 1024;

  function automatic int calc_addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int calc_lane_w(
    input int data_w,
    input int lanes
  );
    return data_w / lanes;
  endfunction

  function automatic logic lane_parity(
    input logic [LANE_W_MAX-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/sram_sp_masked_ctrl_if.sv
// Request/response bundle between the cache pipeline and the SRAM controller.
// The parity injection pin is only used when SRAM_PARITY_EN is defined.
interface sram_sp_masked_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = 7776,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = calc_addr_w(DEPTH),
  parameter int LANES  = 16
);

  logic              req_valid;
  logic              req_ready;
  logic              req_wmode;
  logic [ADDR_W-1:0] req_addr;
  logic [LANES-1:0]  req_wmask;
  logic [DATA_W-1:0] req_wdata;
  logic              inj_par_err;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              init_done;
  logic              par_err;
  logic [LANES-1:0]  par_err_lane;

  modport master (
    output req_valid,
    output req_wmode,
    output req_addr,
    output req_wmask,
    output req_wdata,
    output inj_par_err,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  init_done,
    input  par_err,
    input  par_err_lane
  );

  modport slave (
    input  req_valid,
    input  req_wmode,
    input  req_addr,
    input  req_wmask,
    input  req_wdata,
    input  inj_par_err,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output init_done,
    output par_err,
    output par_err_lane
  );

endinterface

// File: rtl/sram_sp_masked_ctrl_lane_array.sv
// Lane-masked storage with a registered read port that holds between reads.
// With SRAM_PARITY_EN one even-parity bit per lane is stored and checked.
module sram_lane_array
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = 7776,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = calc_addr_w(DEPTH),
  parameter int LANES  = 16,
  parameter int LANE_W = calc_lane_w(DATA_W, LANES)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LANES-1:0]  wmask,
  input  logic [DATA_W-1:0] wdata,
  input  logic              inj,
  input  logic              re,
  input  logic              rzero,
  output logic [DATA_W-1:0] rdata,
  output logic [LANES-1:0]  par_lane
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) begin
          mem[addr][i*LANE_W +: LANE_W] <=
            wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // rzero covers addresses past DEPTH on non-power-of-two arrays.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= rzero ? '0 : mem[addr];
    end
  end

  assign rdata = rdata_q;

`ifdef SRAM_PARITY_EN
  logic [LANES-1:0] pmem [DEPTH];
  logic [LANES-1:0] par_chk;
  logic [LANES-1:0] par_q;

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) begin
          pmem[addr][i] <= inj ^ lane_parity(
            LANE_W_MAX'(wdata[i*LANE_W +: LANE_W]));
        end
      end
    end
  end

  always_comb begin
    par_chk = '0;
    for (int i = 0; i < LANES; i++) begin
      par_chk[i] = pmem[addr][i] ^ lane_parity(
        LANE_W_MAX'(mem[addr][i*LANE_W +: LANE_W]));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      par_q <= '0;
    end else if (re) begin
      par_q <= rzero ? '0 : par_chk;
    end
  end

  assign par_lane = par_q;
`else
  logic unused_inj;
  assign unused_inj = inj;
  assign par_lane   = '0;
`endif

endmodule

// File: rtl/sram_sp_masked_ctrl.sv
// Single-port lane-masked SRAM controller: zero-init after reset, then
// valid/ready requests with 1-cycle reads. Parity: SRAM_PARITY_EN.
module sram_sp_masked_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W        = 7776,
  parameter int DEPTH         = 1024,
  parameter int ADDR_W        = calc_addr_w(DEPTH),
  parameter int LANES         = 16,
  parameter int LANE_W        = calc_lane_w(DATA_W, LANES),
  parameter int INIT_ON_RESET = 1
) (
  input logic                  clock,
  input logic                  reset_n,
  sram_sp_masked_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_W =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH-1);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic              resp_q;
  logic              fire;
  logic              in_range;
  logic              arr_we;
  logic              arr_re;
  logic              arr_inj;
  logic [ADDR_W-1:0] arr_addr;
  logic [LANES-1:0]  arr_mask;
  logic [LANES-1:0]  arr_par;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign fire     = bus.req_valid && (state_q == READY);
  assign in_range = {1'b0, bus.req_addr} < DEPTH_W;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      resp_q  <= arr_re;
    end
  end

  // INIT borrows the array write port to clear one word per cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = bus.req_addr;
    arr_mask  = bus.req_wmask;
    arr_wdata = bus.req_wdata;
    arr_inj   = bus.inj_par_err;
    unique case (state_q)
      INIT: begin
        if (INIT_ON_RESET != 0) begin
          arr_we    = 1'b1;
          arr_addr  = ptr_q;
          arr_mask  = '1;
          arr_wdata = '0;
          arr_inj   = 1'b0;
          if (ptr_q == LAST) begin
            state_d = READY;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end else begin
          state_d = READY;
        end
      end
      READY: begin
        arr_we = fire && bus.req_wmode && in_range;
        arr_re = fire && !bus.req_wmode;
      end
    endcase
  end

  sram_lane_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_array (
    .clock    (clock),
    .reset_n  (reset_n),
    .we       (arr_we),
    .addr     (arr_addr),
    .wmask    (arr_mask),
    .wdata    (arr_wdata),
    .inj      (arr_inj),
    .re       (arr_re),
    .rzero    (!in_range),
    .rdata    (arr_rdata),
    .par_lane (arr_par)
  );

  assign bus.req_ready    = (state_q == READY);
  assign bus.init_done    = (state_q == READY);
  assign bus.resp_valid   = resp_q;
  assign bus.resp_rdata   = arr_rdata;
  assign bus.par_err_lane = resp_q ? arr_par : '0;
  assign bus.par_err      = |bus.par_err_lane;

endmodule

// File: tb/tb_sram_sp_masked_ctrl.sv
// Bench: two controllers (DEPTH 8 and 6) share one stimulus stream and are
// checked against an array model, a vector table and init sequences.
module tb_sram_sp_masked_ctrl;

`ifdef SRAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        wmode;
  logic [2:0]  addr;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic        inj;

  logic        rr [2];
  logic        id [2];
  logic        rv [2];
  logic        pe [2];
  logic [31:0] rd [2];
  logic [3:0]  pl [2];

  sram_sp_masked_ctrl_if #(
    .DATA_W(32), .DEPTH(8), .LANES(4)
  ) if0 ();
  sram_sp_masked_ctrl_if #(
    .DATA_W(32), .DEPTH(6), .LANES(4)
  ) if1 ();

  assign if0.req_valid   = valid;
  assign if0.req_wmode   = wmode;
  assign if0.req_addr    = addr;
  assign if0.req_wmask   = mask;
  assign if0.req_wdata   = wdata;
  assign if0.inj_par_err = inj;
  assign if1.req_valid   = valid;
  assign if1.req_wmode   = wmode;
  assign if1.req_addr    = addr;
  assign if1.req_wmask   = mask;
  assign if1.req_wdata   = wdata;
  assign if1.inj_par_err = inj;

  assign rr[0] = if0.req_ready;
  assign id[0] = if0.init_done;
  assign rv[0] = if0.resp_valid;
  assign pe[0] = if0.par_err;
  assign rd[0] = if0.resp_rdata;
  assign pl[0] = if0.par_err_lane;
  assign rr[1] = if1.req_ready;
  assign id[1] = if1.init_done;
  assign rv[1] = if1.resp_valid;
  assign pe[1] = if1.par_err;
  assign rd[1] = if1.resp_rdata;
  assign pl[1] = if1.par_err_lane;

  sram_sp_masked_ctrl #(
    .DATA_W(32), .DEPTH(8), .LANES(4),
    .INIT_ON_RESET(1)
  ) u_dut0 (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (if0.slave)
  );

  sram_sp_masked_ctrl #(
    .DATA_W(32), .DEPTH(6), .LANES(4),
    .INIT_ON_RESET(1)
  ) u_dut1 (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [31:0] mem  [2][8];
  logic [3:0]  perr [2][8];
  int          cyc  [2];
  logic        e_rv [2];
  logic [31:0] e_rd [2];
  logic [3:0]  e_pl [2];

  typedef struct {
    logic        vld;
    logic        wr;
    logic [2:0]  a;
    logic [3:0]  m;
    logic [31:0] d;
    logic        inj;
    logic        erv;
    logic [31:0] erd0;
    logic [31:0] erd1;
    logic [3:0]  epl;
  } vec_t;

  vec_t tbl [16];

  function automatic int depth_of(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] n,
    input logic [3:0]  m
  );
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (m[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(
    input string       nm,
    input int          k,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s inst%0d: got %h want %h",
               nm, k, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cyc[k]  = 0;
      e_rv[k] = 1'b0;
      e_rd[k] = '0;
      e_pl[k] = '0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic rdy;
      rdy = rst_n && (cyc[k] >= depth_of(k));
      chk("req_ready", k, 32'(rr[k]), 32'(rdy));
      chk("init_done", k, 32'(id[k]), 32'(rdy));
      chk("resp_valid", k, 32'(rv[k]), 32'(e_rv[k]));
      chk("resp_rdata", k, rd[k], e_rd[k]);
      chk("par_err", k, 32'(pe[k]), 32'(|e_pl[k]));
      chk("par_err_lane", k, 32'(pl[k]), 32'(e_pl[k]));
    end
  endtask

  // Predict the effect of the coming edge, clock it, then compare.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      int   d;
      logic fire;
      d = depth_of(k);
      if (!rst_n) begin
        cyc[k]  = 0;
        e_rv[k] = 1'b0;
        e_rd[k] = '0;
        e_pl[k] = '0;
      end else begin
        fire    = valid && (cyc[k] >= d);
        e_rv[k] = 1'b0;
        e_pl[k] = '0;
        if (cyc[k] == d - 1) begin
          for (int a = 0; a < 8; a++) begin
            mem[k][a]  = '0;
            perr[k][a] = '0;
          end
        end
        if (fire && !wmode) begin
          e_rv[k] = 1'b1;
          e_rd[k] = (addr < d) ? mem[k][addr] : '0;
          e_pl[k] = (addr < d) ? perr[k][addr] : '0;
        end
        if (fire && wmode && addr < d) begin
          mem[k][addr] = merge(mem[k][addr], wdata, mask);
          for (int i = 0; i < 4; i++)
            if (mask[i]) perr[k][addr][i] = inj & PAR;
        end
        if (cyc[k] < d) cyc[k]++;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int fr [2];
    int fv [2];

    tbl[0]  = '{1,1,3'd2,4'hF,32'hAABBCCDD,0,0,
                32'h0,32'h0,4'h0};
    tbl[1]  = '{1,1,3'd2,4'h5,32'h11223344,0,0,
                32'h0,32'h0,4'h0};
    tbl[2]  = '{1,0,3'd2,4'h0,32'h0,0,1,
                32'hAA22CC44,32'hAA22CC44,4'h0};
    tbl[3]  = '{1,1,3'd5,4'hF,32'h12345678,0,0,
                32'hAA22CC44,32'hAA22CC44,4'h0};
    tbl[4]  = '{1,0,3'd5,4'h0,32'h0,0,1,
                32'h12345678,32'h12345678,4'h0};
    tbl[5]  = '{1,1,3'd1,4'hF,32'hDEADBEEF,0,0,
                32'h12345678,32'h12345678,4'h0};
    tbl[6]  = '{0,0,3'd0,4'h0,32'h0,0,0,
                32'h12345678,32'h12345678,4'h0};
    tbl[7]  = '{0,1,3'd5,4'hF,32'hFFFFFFFF,0,0,
                32'h12345678,32'h12345678,4'h0};
    tbl[8]  = '{1,1,3'd7,4'hF,32'hCAFEF00D,0,0,
                32'h12345678,32'h12345678,4'h0};
    tbl[9]  = '{1,0,3'd7,4'h0,32'h0,0,1,
                32'hCAFEF00D,32'h0,4'h0};
    tbl[10] = '{1,0,3'd1,4'h0,32'h0,0,1,
                32'hDEADBEEF,32'hDEADBEEF,4'h0};
    tbl[11] = '{1,1,3'd3,4'h3,32'h000001FF,1,0,
                32'hDEADBEEF,32'hDEADBEEF,4'h0};
    tbl[12] = '{1,0,3'd3,4'h0,32'h0,0,1,
                32'h000001FF,32'h000001FF,
                PAR ? 4'h3 : 4'h0};
    tbl[13] = '{1,1,3'd3,4'h3,32'h000001FF,0,0,
                32'h000001FF,32'h000001FF,4'h0};
    tbl[14] = '{1,0,3'd3,4'h0,32'h0,0,1,
                32'h000001FF,32'h000001FF,4'h0};
    tbl[15] = '{1,0,3'd0,4'h0,32'h0,0,1,
                32'h0,32'h0,4'h0};

    valid = 0; wmode = 0; addr = 0;
    mask = 0; wdata = 0; inj = 0;
    rst_n = 0;
    model_reset();
    repeat (3) step();

    rst_n = 1;
    repeat (3) step();

    // Reset mid-init restarts the whole clear sequence.
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    step();

    // Hold a read of addr 0 from release: it must stall until READY.
    valid = 1; wmode = 0; addr = 0;
    rst_n = 1;
    fr[0] = -1; fr[1] = -1;
    fv[0] = -1; fv[1] = -1;
    for (int n = 1; n <= 12; n++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        if (fr[k] < 0 && rr[k]) fr[k] = n;
        if (fv[k] < 0 && rv[k]) fv[k] = n;
      end
    end
    chk("first_ready", 0, fr[0], 8);
    chk("first_ready", 1, fr[1], 6);
    chk("first_resp", 0, fv[0], 9);
    chk("first_resp", 1, fv[1], 7);

    for (int a = 0; a < 8; a++) begin
      valid = 1; wmode = 0; addr = 3'(a);
      step();
      chk("init_zero", 0, rd[0], 32'h0);
      chk("init_zero", 1, rd[1], 32'h0);
    end

    for (int i = 0; i < 16; i++) begin
      valid = tbl[i].vld;
      wmode = tbl[i].wr;
      addr  = tbl[i].a;
      mask  = tbl[i].m;
      wdata = tbl[i].d;
      inj   = tbl[i].inj;
      step();
      chk("tbl_rv", 0, 32'(rv[0]), 32'(tbl[i].erv));
      chk("tbl_rv", 1, 32'(rv[1]), 32'(tbl[i].erv));
      chk("tbl_rd", 0, rd[0], tbl[i].erd0);
      chk("tbl_rd", 1, rd[1], tbl[i].erd1);
      chk("tbl_pl", 0, 32'(pl[0]), 32'(tbl[i].epl));
    end

    for (int i = 0; i < 400; i++) begin
      valid = 1'($urandom_range(0, 3) != 0);
      wmode = 1'($urandom_range(0, 1));
      addr  = 3'($urandom_range(0, 7));
      mask  = 4'($urandom_range(0, 15));
      wdata = $urandom;
      inj   = 1'($urandom_range(0, 3) == 0);
      step();
    end

    valid = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/sram_sp_masked_ctrl.md
Name: sram_sp_masked_ctrl

Overview:
- Next-generation single-port, lane-masked SRAM model with a controller, for cache data/tag arrays.
- Generalised in width, depth and lane count.
- Adds a valid/ready request handshake, automatic zero-initialisation after reset, an init-done indication and a read-response valid.
- Read data holds stable between reads.
- Sits between the cache pipeline and the storage array.

Parameters:
- DATA_W, 7776, total word width in bits.
- DEPTH, 1024, number of words; any value >= 2, not necessarily a power of two.
- ADDR_W, $clog2(DEPTH), address width (derived).
- LANES, 16, number of write-mask lanes; DATA_W must be divisible by LANES.
- LANE_W, DATA_W/LANES, bits per lane (derived).
- INIT_ON_RESET, 1, when 1 the controller clears every word after reset; when 0 it skips init.

Ports:
- clock  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts a request this cycle
- req_wmode  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wmask  in  LANES  per-lane write enable; ignored on reads
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  read data valid (one-cycle pulse)
- resp_rdata  out  DATA_W  read data
- init_done  out  1  high once the array is usable
- par_err  out  1  parity error flag, qualified by resp_valid
- par_err_lane  out  LANES  per-lane parity error vector
- inj_par_err  in  1  parity error injection; only used with SRAM_PARITY_EN

Behaviour:
- Reset values (asynchronous, reset_n low):
  - state=INIT, init_ptr=0
  - req_ready=0, init_done=0, resp_valid=0
  - resp_rdata=0, par_err=0, par_err_lane=0
  - Array contents are not reset.
- FSM state INIT:
  - With INIT_ON_RESET=1: each cycle write all lanes of word init_ptr with zero data and zero parity, then init_ptr++.
  - When init_ptr==DEPTH-1 is written, go to READY on the next edge.
  - Init takes exactly DEPTH cycles.
  - With INIT_ON_RESET=0: INIT lasts one cycle and array contents are undefined.
  - req_ready=0 throughout INIT; requests are not accepted or dropped, they stall.
- FSM state READY:
  - init_done=1 and req_ready=1 every cycle; this is the terminal state until reset.
- Reset asserted mid-init: returns to INIT with init_ptr=0 and the full init restarts.
- Handshake: a request fires when req_valid && req_ready. There is no response backpressure.
- Write:
  - Lanes i with req_wmask[i]=1 get bits [i*LANE_W +: LANE_W] written on the firing edge; other lanes are unchanged.
  - No response is generated; an all-zero mask is a legal no-op.
- Read:
  - Address is captured on the firing edge.
  - resp_valid=1 exactly one cycle later, with resp_rdata = word contents.
  - Latency is 1 and one read per cycle is sustained.
- Read data hold: resp_rdata is a register and keeps the last read value until the next read response; writes never disturb it.
- Write then read to the same address on consecutive cycles: the read returns the new data.
- Out-of-range address (addr >= DEPTH when DEPTH is not a power of two):
  - Writes are ignored.
  - Reads return resp_valid=1 with resp_rdata=0.

Optional Feature:
- Macro: SRAM_PARITY_EN.
- When defined:
  - Storage is widened by LANES bits, one even-parity bit per lane, written with that lane's data.
  - inj_par_err=1 during a write inverts the stored parity bit of every written lane.
  - On each read response, par_err_lane[i] = stored parity XOR recomputed parity of lane i.
  - par_err = |par_err_lane, valid with resp_valid; both are 0 in cycles without resp_valid.
- When undefined: no parity storage; par_err and par_err_lane are tied 0 and inj_par_err is ignored.

Decomposition:
- Package sram_ctrl_pkg holds:
  - state enum {INIT, READY}
  - function lane_parity(LANE_W data) returning 1 bit
  - localparam derivation helpers for ADDR_W and LANE_W
- One sub-module, sram_lane_array: the raw lane-masked storage plus registered read address/data (parity bits included when enabled).
- The top level holds the FSM, init pointer, handshake and response logic.

Test Plan:
- Init and reset: DEPTH=8, INIT_ON_RESET=1; release reset.
  - Required: req_ready=0 and init_done=0 for 8 cycles, then both 1.
  - Reads of all 8 addresses return 0.
  - Also assert reset_n low at init cycle 3, then release: init restarts and again takes 8 cycles.
- Masked write: LANES=4, LANE_W=8.
  - Write addr 2, data 0xAABBCCDD, mask 0xF; then write data 0x11223344, mask 0x5; then read addr 2.
  - Required: resp_valid 1 cycle after the read, resp_rdata=0xAA22CC44.
- Back-to-back and hold: write addr 5 = 0x12345678 (full mask); read addr 5 the next cycle; then idle 3 cycles with a write to addr 1.
  - Required: resp_rdata=0x12345678 and stays 0x12345678 during the idle cycles; resp_valid pulses once.
- Stall during init: req_valid=1 read addr 0 held from reset release.
  - Required: fires only on the first READY cycle; resp_valid on the following cycle with data 0.
- Parity (SRAM_PARITY_EN, LANES=4): write addr 3 mask 0x3 with inj_par_err=1, then read addr 3.
  - Required: par_err=1, par_err_lane=0x3.
  - Rewriting with inj_par_err=0 and reading again gives par_err=0.
- Out-of-range, DEPTH=6: write addr 7, then read addr 7.
  - Required: no array change (all words still 0) and the read returns 0 with resp_valid=1.
